// File: rtl/dcm_drp_reconfig_ctrl_if.sv
// Request and DRP signal bundle between the DCM reconfiguration controller and
// its environment (requesting host, DCM_ADV DRP port and LOCKED status).
interface dcm_drp_reconfig_ctrl_if;
  logic        req;
  logic [5:0]  mult;
  logic [5:0]  div;
  logic        busy;
  logic        done;
  logic        err;
  logic [1:0]  err_code;
  logic        dcm_rst;
  logic [6:0]  daddr;
  logic [15:0] di;
  logic        den;
  logic        dwe;
  logic [15:0] drp_do;
  logic        drdy;
  logic        locked;

  // Host/DCM side: issues requests, answers DRP accesses, reports lock.
  modport master (
    output req, mult, div, drp_do, drdy, locked,
    input  busy, done, err, err_code, dcm_rst, daddr, di, den, dwe
  );

  // Controller side.
  modport slave (
    input  req, mult, div, drp_do, drdy, locked,
    output busy, done, err, err_code, dcm_rst, daddr, di, den, dwe
  );
endinterface

// File: rtl/dcm_drp_reconfig_ctrl.sv
// Runtime CLKFX M/D reprogramming of a DCM_ADV over DRP: hold DCM in reset,
// read-modify-write the M/D register, release reset and wait for LOCKED.
module dcm_drp_reconfig_ctrl #(
  parameter logic [6:0]  DRP_ADDR     = 7'h50,
  parameter logic [15:0] FIELD_MASK   = 16'h1F1F,
  parameter int unsigned RST_HOLD_CYC = 8,
  parameter int unsigned DRDY_TIMEOUT = 64,
  parameter int unsigned LOCK_TIMEOUT = 1000000
) (
  input logic                    dclk_i,
  input logic                    rst_n_i,
  dcm_drp_reconfig_ctrl_if.slave ctrl_if
);

  localparam int unsigned LIM_A   = (DRDY_TIMEOUT > RST_HOLD_CYC) ? DRDY_TIMEOUT : RST_HOLD_CYC;
  localparam int unsigned MAX_LIM = (LIM_A > LOCK_TIMEOUT) ? LIM_A : LOCK_TIMEOUT;
  localparam int unsigned CNT_W   = $clog2(MAX_LIM + 1);

  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_ILLEGAL = 2'b01;
  localparam logic [1:0] ERR_DRDY    = 2'b10;
  localparam logic [1:0] ERR_LOCK    = 2'b11;

  typedef enum logic [3:0] {
    S_IDLE, S_CHECK, S_ASSERT, S_RD, S_RD_WAIT, S_WR, S_WR_WAIT, S_HOLD, S_LOCK_WAIT
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [5:0]         mult_q, mult_d;
  logic [5:0]         div_q, div_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               err_q, err_d;
  logic [1:0]         err_code_q, err_code_d;
  logic               dcm_rst_q, dcm_rst_d;
  logic [6:0]         daddr_q, daddr_d;
  logic [15:0]        di_q, di_d;
  logic               den_q, den_d;
  logic               dwe_q, dwe_d;

  logic               md_legal_c;
  logic [15:0]        new_md_c;
  logic [15:0]        merged_c;
  logic [CNT_W-1:0]   cnt_lim_c;
  logic               expired_c;

  assign md_legal_c = (mult_q >= 6'd2) && (mult_q <= 6'd32) &&
                      (div_q >= 6'd1) && (div_q <= 6'd32);
  assign new_md_c   = {3'b000, 5'(mult_q - 6'd1), 3'b000, 5'(div_q - 6'd1)};
  assign merged_c   = (ctrl_if.drp_do & ~FIELD_MASK) | (new_md_c & FIELD_MASK);

  // Terminal count of the shared wait counter for the current wait state.
  always_comb begin
    cnt_lim_c = '0;
    case (state_q)
      S_RD_WAIT, S_WR_WAIT: cnt_lim_c = CNT_W'(DRDY_TIMEOUT - 1);
      S_HOLD:               cnt_lim_c = CNT_W'(RST_HOLD_CYC - 1);
      S_LOCK_WAIT:          cnt_lim_c = CNT_W'(LOCK_TIMEOUT - 1);
      default:              cnt_lim_c = '0;
    endcase
  end

  assign expired_c = (cnt_q == cnt_lim_c);

  // State and output registers; reset lands in HOLD so a startup lock sequence runs.
  always_ff @(posedge dclk_i) begin
    if (!rst_n_i) begin
      state_q    <= S_HOLD;
      cnt_q      <= '0;
      mult_q     <= '0;
      div_q      <= '0;
      busy_q     <= 1'b1;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      err_code_q <= ERR_NONE;
      dcm_rst_q  <= 1'b1;
      daddr_q    <= '0;
      di_q       <= '0;
      den_q      <= 1'b0;
      dwe_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      mult_q     <= mult_d;
      div_q      <= div_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
      err_code_q <= err_code_d;
      dcm_rst_q  <= dcm_rst_d;
      daddr_q    <= daddr_d;
      di_q       <= di_d;
      den_q      <= den_d;
      dwe_q      <= dwe_d;
    end
  end

  // Next-state logic; DRDY is only honoured in the two DRP wait states.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:      if (ctrl_if.req) state_d = S_CHECK;
      S_CHECK:     state_d = md_legal_c ? S_ASSERT : S_IDLE;
      S_ASSERT:    state_d = S_RD;
      S_RD:        state_d = S_RD_WAIT;
      S_RD_WAIT: begin
        if (ctrl_if.drdy)   state_d = S_WR;
        else if (expired_c) state_d = S_IDLE;
      end
      S_WR:        state_d = S_WR_WAIT;
      S_WR_WAIT: begin
        if (ctrl_if.drdy)   state_d = S_HOLD;
        else if (expired_c) state_d = S_IDLE;
      end
      S_HOLD:      if (expired_c) state_d = S_LOCK_WAIT;
      S_LOCK_WAIT: begin
        if (ctrl_if.locked) state_d = S_IDLE;
        else if (expired_c) state_d = S_IDLE;
      end
      default:     state_d = S_IDLE;
    endcase
  end

  // Next values of the registered outputs, counter and latched M/D.
  always_comb begin
    cnt_d      = cnt_q;
    mult_d     = mult_q;
    div_d      = div_q;
    busy_d     = (state_d != S_IDLE);
    done_d     = 1'b0;
    err_d      = 1'b0;
    err_code_d = err_code_q;
    dcm_rst_d  = dcm_rst_q;
    daddr_d    = daddr_q;
    di_d       = di_q;
    den_d      = 1'b0;
    dwe_d      = 1'b0;

    if (state_d != state_q)  cnt_d = '0;
    else if (cnt_q != '1)    cnt_d = cnt_q + CNT_W'(1);

    case (state_q)
      S_IDLE: begin
        if (ctrl_if.req) begin
          mult_d     = ctrl_if.mult;
          div_d      = ctrl_if.div;
          err_code_d = ERR_NONE;
        end
      end
      S_CHECK: begin
        if (!md_legal_c) begin
          err_d      = 1'b1;
          err_code_d = ERR_ILLEGAL;
        end
      end
      S_RD_WAIT: begin
        if (ctrl_if.drdy) begin
          di_d = merged_c;
        end else if (expired_c) begin
          err_d      = 1'b1;
          err_code_d = ERR_DRDY;
        end
      end
      S_WR_WAIT: begin
        if (!ctrl_if.drdy && expired_c) begin
          err_d      = 1'b1;
          err_code_d = ERR_DRDY;
        end
      end
      S_LOCK_WAIT: begin
        if (ctrl_if.locked) begin
          done_d = 1'b1;
        end else if (expired_c) begin
          err_d      = 1'b1;
          err_code_d = ERR_LOCK;
        end
      end
      default: ;
    endcase

    // DCM_RST keeps its last value in IDLE/CHECK, so a DRDY abort leaves the DCM held.
    case (state_d)
      S_ASSERT, S_RD_WAIT, S_WR_WAIT, S_HOLD: dcm_rst_d = 1'b1;
      S_RD: begin
        dcm_rst_d = 1'b1;
        den_d     = 1'b1;
        daddr_d   = DRP_ADDR;
      end
      S_WR: begin
        dcm_rst_d = 1'b1;
        den_d     = 1'b1;
        dwe_d     = 1'b1;
        daddr_d   = DRP_ADDR;
      end
      S_LOCK_WAIT: dcm_rst_d = 1'b0;
      default: ;
    endcase
  end

  assign ctrl_if.busy     = busy_q;
  assign ctrl_if.done     = done_q;
  assign ctrl_if.err      = err_q;
  assign ctrl_if.err_code = err_code_q;
  assign ctrl_if.dcm_rst  = dcm_rst_q;
  assign ctrl_if.daddr    = daddr_q;
  assign ctrl_if.di       = di_q;
  assign ctrl_if.den      = den_q;
  assign ctrl_if.dwe      = dwe_q;

endmodule

// File: tb/tb_dcm_drp_reconfig_ctrl.sv
// Bench for dcm_drp_reconfig_ctrl: a behavioural DRP register/DCM lock model
// answers the controller while directed and random requests are checked.
module tb_dcm_drp_reconfig_ctrl;
  localparam int unsigned RST_HOLD = 8;
  localparam int unsigned DRDY_TO  = 64;
  localparam int unsigned LOCK_TO  = 300;
  localparam logic [15:0] MASK     = 16'h1F1F;
  localparam logic [6:0]  ADDR     = 7'h50;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  dcm_drp_reconfig_ctrl_if bus ();

  dcm_drp_reconfig_ctrl #(
    .DRP_ADDR    (ADDR),
    .FIELD_MASK  (MASK),
    .RST_HOLD_CYC(RST_HOLD),
    .DRDY_TIMEOUT(DRDY_TO),
    .LOCK_TIMEOUT(LOCK_TO)
  ) dut (
    .dclk_i (clk),
    .rst_n_i(rst_n),
    .ctrl_if(bus)
  );

  int n_chk = 0, n_err = 0, cyc = 0;
  logic [15:0] drp_reg, pend_di, last_wr_di;
  logic [6:0]  last_wr_addr, last_rd_addr;
  int  pend = -1, drdy_lat = 3, lock_cnt = -1, lock_lat = 20;
  bit  pend_wr, drdy_on = 1, lock_on = 1, spam = 0, prev_rst = 1;
  int  rst_run = 0, run_at_fall = 0, fall_tick = 0, last_drdy_tick = 0;
  int  den_n = 0, dwe_n = 0, den_tick = 0, done_tick = 0, err_tick = 0;
  int  lock_hi_tick = 0, req_tick = 0, both_hi = 0, dwe_alone = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] md_word(input logic [15:0] old, input int m, input int d);
    int fld;
    fld = (m - 1) * 256 + (d - 1);
    return (old & ~MASK) | (16'(fld) & MASK);
  endfunction

  // One DCLK cycle: observe outputs after the edge, then play DRP slave and DCM.
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    bus.drdy = 1'b0;
    if (pend > 0) begin
      pend--;
      if (pend == 0) begin
        bus.drdy = 1'b1;
        bus.drp_do = pend_wr ? 16'($urandom) : drp_reg;
        if (pend_wr) drp_reg = pend_di;
        last_drdy_tick = cyc;
        pend = -1;
      end
    end
    if (lock_cnt > 0) begin
      lock_cnt--;
      if (lock_cnt == 0 && lock_on) begin
        bus.locked = 1'b1;
        lock_hi_tick = cyc;
      end
    end
    if (bus.done && bus.err) both_hi++;
    if (bus.done) done_tick = cyc;
    if (bus.err) err_tick = cyc;
    if (bus.dwe && !bus.den) dwe_alone++;
    if (bus.den) begin
      den_n++;
      den_tick = cyc;
      if (bus.dwe) begin
        dwe_n++;
        last_wr_di = bus.di;
        last_wr_addr = bus.daddr;
      end else begin
        last_rd_addr = bus.daddr;
      end
      if (drdy_on) begin
        pend = drdy_lat;
        pend_wr = bus.dwe;
        pend_di = bus.di;
      end
    end
    if (bus.dcm_rst) begin
      rst_run++;
      bus.locked = 1'b0;
      lock_cnt = -1;
    end else if (prev_rst) begin
      fall_tick = cyc;
      run_at_fall = rst_run;
      rst_run = 0;
      lock_cnt = lock_lat;
    end
    prev_rst = bus.dcm_rst;
    if (spam) begin
      bus.req  = bus.busy;
      bus.mult = 6'($urandom);
      bus.div  = 6'($urandom);
    end
  endtask

  task automatic wait_end(input int budget);
    bit hit;
    hit = 1'b0;
    for (int i = 0; i < budget && !hit; i++) begin
      tick();
      hit = bus.done || bus.err;
    end
    check("seq_end_reached", 32'(hit), 1);
  endtask

  task automatic do_req(input int m, input int d);
    bus.req  = 1'b1;
    bus.mult = 6'(m);
    bus.div  = 6'(d);
    req_tick = cyc;
    tick();
    if (!spam) bus.req = 1'b0;
    check("accept_busy", 32'(bus.busy), 1);
    check("accept_code_clr", 32'(bus.err_code), 0);
  endtask

  // The sample taken right after the last reset edge is already the first HOLD cycle.
  task automatic release_rst();
    rst_n = 1'b1;
    rst_run = 1;
  endtask

  initial begin
    int den0, dwe0, m, d;
    int ill_m[4] = '{1, 5, 33, 0};
    int ill_d[4] = '{3, 33, 4, 10};
    logic [15:0] exp_w;

    rst_n = 1'b0;
    bus.req = 1'b0; bus.mult = '0; bus.div = '0;
    bus.drp_do = '0; bus.drdy = 1'b0; bus.locked = 1'b0;
    drp_reg = 16'hA0C0;

    // Reset state and startup lock sequence
    repeat (3) tick();
    check("rst_busy", 32'(bus.busy), 1);
    check("rst_dcm_rst", 32'(bus.dcm_rst), 1);
    check("rst_den", 32'(bus.den), 0);
    check("rst_dwe", 32'(bus.dwe), 0);
    check("rst_done_err", 32'({bus.done, bus.err}), 0);
    check("rst_code", 32'(bus.err_code), 0);
    check("rst_daddr", 32'(bus.daddr), 0);
    check("rst_di", 32'(bus.di), 0);
    release_rst();
    lock_lat = 20;
    wait_end(200);
    check("t1_done", 32'(bus.done), 1);
    check("t1_busy", 32'(bus.busy), 0);
    check("t1_hold_len", 32'(run_at_fall), RST_HOLD);
    check("t1_lock_to_done", 32'(done_tick - lock_hi_tick), 1);

    // Directed read-modify-write
    den0 = den_n; dwe0 = dwe_n;
    do_req(5, 3);
    wait_end(400);
    check("t2_done", 32'(bus.done), 1);
    check("t2_den_cnt", 32'(den_n - den0), 2);
    check("t2_dwe_cnt", 32'(dwe_n - dwe0), 1);
    check("t2_rd_addr", 32'(last_rd_addr), 32'h50);
    check("t2_wr_addr", 32'(last_wr_addr), 32'h50);
    check("t2_wr_di", 32'(last_wr_di), 32'hA4C2);
    check("t2_reg", 32'(drp_reg), 32'hA4C2);
    check("t2_hold_len", 32'(fall_tick - last_drdy_tick), RST_HOLD + 1);
    check("t2_lock_to_done", 32'(done_tick - lock_hi_tick), 1);
    check("t2_dcm_rst", 32'(bus.dcm_rst), 0);

    // Illegal M/D values
    for (int k = 0; k < 4; k++) begin
      den0 = den_n;
      do_req(ill_m[k], ill_d[k]);
      wait_end(20);
      check("t3_err", 32'(bus.err), 1);
      check("t3_code", 32'(bus.err_code), 1);
      check("t3_latency", 32'(err_tick - req_tick), 2);
      check("t3_no_den", 32'(den_n - den0), 0);
      check("t3_dcm_rst", 32'(bus.dcm_rst), 0);
    end

    // DRDY never returns on the read
    drdy_on = 1'b0;
    den0 = den_n; dwe0 = dwe_n;
    do_req(10, 4);
    wait_end(200);
    check("t4_err", 32'(bus.err), 1);
    check("t4_code", 32'(bus.err_code), 2);
    check("t4_timeout", 32'(err_tick - den_tick), DRDY_TO + 1);
    check("t4_den_cnt", 32'(den_n - den0), 1);
    check("t4_no_write", 32'(dwe_n - dwe0), 0);
    repeat (5) tick();
    check("t4_code_held", 32'(bus.err_code), 2);
    check("t4_dcm_rst_held", 32'(bus.dcm_rst), 1);
    drdy_on = 1'b1;

    // LOCKED held low, REQ hammered while busy
    lock_on = 1'b0;
    spam = 1'b1;
    den0 = den_n;
    do_req(7, 2);
    wait_end(LOCK_TO + 200);
    check("t5_err", 32'(bus.err), 1);
    check("t5_code", 32'(bus.err_code), 3);
    check("t5_timeout", 32'(err_tick - fall_tick), LOCK_TO);
    check("t5_den_cnt", 32'(den_n - den0), 2);
    check("t5_dcm_rst", 32'(bus.dcm_rst), 0);
    spam = 1'b0;
    bus.req = 1'b0;
    lock_on = 1'b1;
    tick();
    check("t5_busy_after", 32'(bus.busy), 0);

    // Random legal requests, corner M/D first
    for (int k = 0; k < 8; k++) begin
      m = (k == 0) ? 32 : (k == 1) ? 2 : int'($urandom_range(2, 32));
      d = (k == 0) ? 32 : (k == 1) ? 1 : int'($urandom_range(1, 32));
      drp_reg  = 16'($urandom);
      drdy_lat = int'($urandom_range(1, 8));
      lock_lat = int'($urandom_range(1, 30));
      exp_w = md_word(drp_reg, m, d);
      den0 = den_n;
      do_req(m, d);
      wait_end(500);
      check("t6_done", 32'(bus.done), 1);
      check("t6_wr_di", 32'(last_wr_di), 32'(exp_w));
      check("t6_reg", 32'(drp_reg), 32'(exp_w));
      check("t6_den_cnt", 32'(den_n - den0), 2);
      check("t6_lock_to_done", 32'(done_tick - lock_hi_tick), 1);
    end

    // Controller reset during WR_WAIT with a late DRDY
    drdy_lat = 6;
    dwe0 = dwe_n;
    do_req(9, 5);
    for (int i = 0; i < 100 && dwe_n == dwe0; i++) tick();
    check("t7_wr_seen", 32'(dwe_n - dwe0), 1);
    repeat (2) tick();
    rst_n = 1'b0;
    tick();
    check("t7_rst_busy", 32'(bus.busy), 1);
    check("t7_rst_dcm_rst", 32'(bus.dcm_rst), 1);
    check("t7_rst_den", 32'(bus.den), 0);
    release_rst();
    lock_lat = 5;
    den0 = den_n;
    wait_end(200);
    check("t7_done", 32'(bus.done), 1);
    check("t7_no_den", 32'(den_n - den0), 0);
    check("t7_hold_len", 32'(run_at_fall), RST_HOLD);

    check("never_done_and_err", 32'(both_hi), 0);
    check("dwe_only_with_den", 32'(dwe_alone), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
